// File: rtl/spi_init_pkg.sv
// Shared types and defaults for the SPI frame initiator.
package spi_init_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int unsigned DIV_DEF = 16;
  localparam int unsigned W_DEF   = 16;
  localparam int unsigned GAP_DEF = 2;
  localparam int unsigned LAT_W   = 8;
  localparam logic [LAT_W-1:0] LAT_SAT = 8'd255;

endpackage

// File: rtl/sclk_div_tick.sv
// DIV-cycle tick generator; restart holds the phase at zero.
module sclk_div_tick
  import spi_init_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick_c
);

  localparam int unsigned CW = $clog2(DIV + 1);

  logic [CW-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CW'(DIV - 1));

  // Count 0..DIV-1, wrapping on the tick
  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart || o_tick_c) r_cnt <= '0;
    else                                r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/spi_frame_initiator.sv
// SPI frame initiator: one cs-framed transfer of W bits, MSB first, sclk idle low.
// Optional cs-to-cs_ret latency measurement enabled by defining LAT_MEAS_EN.
module spi_frame_initiator
  import spi_init_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEF,
  parameter int unsigned W   = W_DEF,
  parameter int unsigned GAP = GAP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     tx_data,
  input  logic             miso,
  input  logic             cs_ret,
  output logic             cs,
  output logic             sclk,
  output logic             sdo,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     rx_data,
  output logic [LAT_W-1:0] lat,
  output logic             lat_valid
);

  localparam int unsigned BW = $clog2(W + 1);
  localparam int unsigned GW = $clog2(GAP + 2);

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic          r_phase, w_phase_nxt;   // 0: sclk high half, 1: sclk low half
  logic [W-2:0]  r_tx, w_tx_nxt;         // bits still to be sent after the current one
  logic [W-1:0]  r_rx, w_rx_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic          r_cs, w_cs_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          r_sdo, w_sdo_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic [W-1:0]  r_rx_data, w_rx_data_nxt;
  logic          w_tick, w_restart, w_accept;

  sclk_div_tick #(.DIV(DIV)) u_tick (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_restart(w_restart),
    .o_tick_c (w_tick)
  );

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_nxt     = r_bit;
    w_phase_nxt   = r_phase;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;
    w_gap_nxt     = r_gap;
    w_cs_nxt      = r_cs;
    w_sclk_nxt    = r_sclk;
    w_sdo_nxt     = r_sdo;
    w_done_nxt    = 1'b0;
    w_rx_data_nxt = r_rx_data;
    w_restart     = 1'b0;
    w_accept      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_restart = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
          w_tx_nxt    = tx_data[W-2:0];
          w_bit_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_cs_nxt    = 1'b1;
          w_sclk_nxt  = 1'b0;
          w_sdo_nxt   = tx_data[W-1];
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_state_nxt = ST_SHIFT;
          w_phase_nxt = 1'b0;
          w_sclk_nxt  = 1'b1;
          w_rx_nxt    = {r_rx[W-2:0], miso};
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
            w_sclk_nxt  = 1'b0;
            if (r_bit != BW'(W - 1)) begin
              w_sdo_nxt = r_tx[W-2];
              w_tx_nxt  = r_tx << 1;
            end
          end else if (r_bit == BW'(W - 1)) begin
            w_state_nxt = ST_HOLD;
            w_sdo_nxt   = 1'b0;
          end else begin
            w_bit_nxt   = r_bit + BW'(1);
            w_phase_nxt = 1'b0;
            w_sclk_nxt  = 1'b1;
            w_rx_nxt    = {r_rx[W-2:0], miso};
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_state_nxt   = ST_GAP;
          w_cs_nxt      = 1'b0;
          w_done_nxt    = 1'b1;
          w_rx_data_nxt = r_rx;
          w_gap_nxt     = '0;
        end
      end
      ST_GAP: begin
        // The done cycle is the first GAP-state cycle, followed by GAP idle cycles
        w_restart = 1'b1;
        if (r_gap == GW'(GAP)) w_state_nxt = ST_IDLE;
        else                   w_gap_nxt   = r_gap + GW'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit     <= '0;
      r_phase   <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_gap     <= '0;
      r_cs      <= 1'b0;
      r_sclk    <= 1'b0;
      r_sdo     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit     <= w_bit_nxt;
      r_phase   <= w_phase_nxt;
      r_tx      <= w_tx_nxt;
      r_rx      <= w_rx_nxt;
      r_gap     <= w_gap_nxt;
      r_cs      <= w_cs_nxt;
      r_sclk    <= w_sclk_nxt;
      r_sdo     <= w_sdo_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rx_data <= w_rx_data_nxt;
    end
  end

  assign cs      = r_cs;
  assign sclk    = r_sclk;
  assign sdo     = r_sdo;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;

`ifdef LAT_MEAS_EN
  logic [LAT_W-1:0] r_lat_cnt, r_lat;
  logic             r_lat_seen, r_lat_valid;

  // Count cycles from cs rise until cs_ret is first seen; report at done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat_cnt   <= '0;
      r_lat_seen  <= 1'b0;
      r_lat       <= '0;
      r_lat_valid <= 1'b0;
    end else begin
      r_lat_valid <= w_done_nxt;
      if (w_accept) begin
        r_lat_cnt  <= '0;
        r_lat_seen <= 1'b0;
      end else if (r_cs && !r_lat_seen) begin
        if (cs_ret)                  r_lat_seen <= 1'b1;
        else if (r_lat_cnt != LAT_SAT) r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end
      if (w_done_nxt) r_lat <= (r_lat_seen || cs_ret) ? r_lat_cnt : LAT_SAT;
    end
  end

  assign lat       = r_lat;
  assign lat_valid = r_lat_valid;
`else
  logic [1:0] w_unused_lat;

  assign w_unused_lat = {cs_ret, w_accept};
  assign lat          = '0;
  assign lat_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_initiator.sv
// Directed bench for spi_frame_initiator (DIV=2, W=8, GAP=2).
module tb_spi_frame_initiator;

  localparam int unsigned DIV = 2;
  localparam int unsigned W   = 8;
  localparam int unsigned GAP = 2;

  logic         clk = 1'b0;
  logic         rst, start, miso, cs_ret;
  logic [W-1:0] tx_data;
  logic         cs, sclk, sdo, busy, done, lat_valid;
  logic [W-1:0] rx_data;
  logic [7:0]   lat;

  int           miso_mode;  // 0: loop from sdo, 1: tied 1, 2: tied 0
  int           cr_mode;    // 0: cs delayed 5 cycles, 1: held 0
  logic [4:0]   cs_dly = '0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cs_dly <= {cs_dly[3:0], cs};
  assign cs_ret = (cr_mode == 0) ? cs_dly[4] : 1'b0;
  assign miso   = (miso_mode == 0) ? sdo : (miso_mode == 1);

  spi_frame_initiator #(.DIV(DIV), .W(W), .GAP(GAP)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .miso     (miso),
    .cs_ret   (cs_ret),
    .cs       (cs),
    .sclk     (sclk),
    .sdo      (sdo),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .lat      (lat),
    .lat_valid(lat_valid)
  );

  typedef struct {
    logic [7:0] tx;
    int         mode;
    int         crm;
    logic [7:0] exp_rx;
  } vec_t;

  typedef struct {
    logic [2:0] first;    // {cs, busy, sdo} in the first frame cycle
    logic [7:0] sdo_bits;
    logic [7:0] rx;
    logic [7:0] lat_v;
    logic       latv_v;
    int         cs_cyc;
    int         rises;
    int         dones;
    int         pbusy;
    logic       timeout;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one start and observe the whole frame until busy drops
  task automatic run_frame(input logic [7:0] tx, input int mode, input int crm,
                           input int idle, output res_t r);
    logic prev_sclk, seen_done, fin;
    r.first = '0; r.sdo_bits = '0; r.rx = '0; r.lat_v = '0; r.latv_v = 1'b0;
    r.cs_cyc = 0; r.rises = 0; r.dones = 0; r.pbusy = 0; r.timeout = 1'b0;
    miso_mode = mode;
    cr_mode   = crm;
    repeat (idle) @(posedge clk);
    #1 start = 1'b1; tx_data = tx;
    @(posedge clk); #1;
    start   = 1'b0;
    tx_data = ~tx;
    r.first   = {cs, busy, sdo};
    prev_sclk = 1'b0;
    seen_done = 1'b0;
    fin       = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      if (cs) r.cs_cyc++;
      if (sclk && !prev_sclk) begin
        r.rises++;
        r.sdo_bits = {r.sdo_bits[6:0], sdo};
      end
      prev_sclk = sclk;
      if (done) begin
        r.dones++;
        r.rx     = rx_data;
        r.lat_v  = lat;
        r.latv_v = lat_valid;
        seen_done = 1'b1;
      end
      if (seen_done) begin
        if (busy) r.pbusy++;
        else      fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    r.timeout = !fin;
  endtask

  vec_t vecs[6];
  res_t r;

  initial begin
    int         td, tr, dn, rs;
    logic       prev_cs;
    logic [7:0] got, exp_lat;
    logic       exp_latv;

    vecs[0] = '{8'hA5, 0, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1, 0, 8'hFF};
    vecs[2] = '{8'hC3, 2, 1, 8'h00};
    vecs[3] = '{8'h01, 0, 1, 8'h01};
    vecs[4] = '{8'h80, 0, 0, 8'h80};
    vecs[5] = '{8'h7E, 1, 1, 8'hFF};

    rst = 1'b1; start = 1'b0; tx_data = '0; miso_mode = 0; cr_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cs", 32'(cs), 0);
    chk("reset_sclk", 32'(sclk), 0);
    chk("reset_sdo", 32'(sdo), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_lat", 32'(lat), 0);
    chk("reset_lat_valid", 32'(lat_valid), 0);
    rst = 1'b0;

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].tx, vecs[i].mode, vecs[i].crm, 6, r);
`ifdef LAT_MEAS_EN
      exp_lat  = (vecs[i].crm == 0) ? 8'd5 : 8'd255;
      exp_latv = 1'b1;
`else
      exp_lat  = 8'd0;
      exp_latv = 1'b0;
`endif
      chk($sformatf("v%0d_timeout", i), 32'(r.timeout), 0);
      chk($sformatf("v%0d_first_cycle", i), 32'(r.first), 32'({2'b11, vecs[i].tx[7]}));
      chk($sformatf("v%0d_sdo_bits", i), 32'(r.sdo_bits), 32'(vecs[i].tx));
      chk($sformatf("v%0d_sclk_rises", i), 32'(r.rises), W);
      chk($sformatf("v%0d_cs_high", i), 32'(r.cs_cyc), (2 * W + 2) * DIV);
      chk($sformatf("v%0d_done_count", i), 32'(r.dones), 1);
      chk($sformatf("v%0d_rx_data", i), 32'(r.rx), 32'(vecs[i].exp_rx));
      chk($sformatf("v%0d_busy_after_done", i), 32'(r.pbusy), GAP + 1);
      chk($sformatf("v%0d_lat", i), 32'(r.lat_v), 32'(exp_lat));
      chk($sformatf("v%0d_lat_valid", i), 32'(r.latv_v), 32'(exp_latv));
    end

    // Start pulsed mid-frame is dropped, tx_data change is ignored
    miso_mode = 0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1; tx_data = 8'h3C;
    @(posedge clk); #1 start = 1'b0; tx_data = 8'h00;
    repeat (9) begin
      @(posedge clk); #1;
    end
    start = 1'b1; tx_data = 8'hFF;
    @(posedge clk); #1 start = 1'b0;
    dn = 0; rs = 0; got = '0; prev_cs = cs;
    for (int n = 0; n < 120; n++) begin
      @(posedge clk); #1;
      if (done) begin dn++; got = rx_data; end
      if (cs && !prev_cs) rs++;
      prev_cs = cs;
    end
    chk("ignored_start_done_count", 32'(dn), 1);
    chk("ignored_start_cs_rises", 32'(rs), 0);
    chk("ignored_start_rx_data", 32'(got), 32'h3C);

    // Start held high: next cs rise GAP+2 cycles after done
    #1 start = 1'b1; tx_data = 8'h5A;
    td = -1; tr = -1; prev_cs = cs;
    for (int n = 0; n < 300 && tr < 0; n++) begin
      @(posedge clk); #1;
      if (done && td < 0) td = n;
      if (td >= 0 && n > td && cs && !prev_cs) tr = n;
      prev_cs = cs;
    end
    start = 1'b0;
    chk("held_start_restart_gap", 32'(tr - td), GAP + 2);
    for (int n = 0; n < 300 && busy; n++) begin
      @(posedge clk); #1;
    end
    chk("held_start_second_frame_ends", 32'(busy), 0);
    chk("held_start_rx_data", 32'(rx_data), 32'h5A);

    // Reset during SHIFT aborts; next start runs a clean frame
    repeat (6) @(posedge clk);
    #1 start = 1'b1; tx_data = 8'h3C;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 50 && !sclk; n++) begin
      @(posedge clk); #1;
    end
    chk("abort_reached_shift", 32'(sclk), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_outputs", 32'({cs, sclk, sdo, busy, done}), 0);
    chk("abort_rx_data", 32'(rx_data), 0);
    run_frame(8'h96, 0, 0, 2, r);
    chk("post_abort_timeout", 32'(r.timeout), 0);
    chk("post_abort_sdo_bits", 32'(r.sdo_bits), 32'h96);
    chk("post_abort_cs_high", 32'(r.cs_cyc), (2 * W + 2) * DIV);
    chk("post_abort_done_count", 32'(r.dones), 1);
    chk("post_abort_rx_data", 32'(r.rx), 32'h96);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_initiator.md
SPI_FRAME_INITIATOR -- requirements
Module: spi_frame_initiator

Interface
REQ-001 The module SHALL have parameter DIV, default 16: SCLK half-period in clk cycles; legal range 1..255.
REQ-002 The module SHALL have parameter W, default 16: frame width in bits; legal range 2..32.
REQ-003 The module SHALL have parameter GAP, default 2: minimum idle clk cycles after done before the next start is accepted; legal range 0..255.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port start, input, 1 bit: frame request, sampled only while idle.
REQ-007 The module SHALL have port tx_data, input, W bits: frame payload, latched on start acceptance and sent MSB first.
REQ-008 The module SHALL have port miso, input, 1 bit: return data.
REQ-009 The module SHALL have port cs_ret, input, 1 bit: returned (delayed) copy of cs, used for latency measurement.
REQ-010 The module SHALL have port cs, output, 1 bit: chip select, active-high.
REQ-011 The module SHALL have port sclk, output, 1 bit: serial clock, idle low.
REQ-012 The module SHALL have port sdo, output, 1 bit: serial data out.
REQ-013 The module SHALL have port busy, output, 1 bit: high from start acceptance through the end of GAP.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 The module SHALL have port rx_data, output, W bits: received frame, updated in the done cycle.
REQ-016 The module SHALL have port lat, output, 8 bits: measured cs-to-cs_ret latency in clk cycles.
REQ-017 The module SHALL have port lat_valid, output, 1 bit: lat is valid; asserted together with done.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-019 In IDLE with start=1, the module SHALL latch tx_data and, on the next cycle, drive cs=1, sdo=tx_data[W-1] and busy=1, and enter SETUP.
REQ-020 SETUP SHALL last DIV cycles with sclk=0, then enter SHIFT.
REQ-021 SHIFT SHALL produce W sclk periods of 2*DIV cycles each: sclk high for DIV cycles, then low for DIV cycles.
REQ-022 On the clk edge that raises sclk, the module SHALL shift miso into the rx register, MSB first.
REQ-023 On each sclk falling edge except the last, the module SHALL present the next tx bit on sdo.
REQ-024 After the W-th falling edge, the module SHALL enter HOLD: cs=1, sclk=0, sdo=0 for DIV cycles.
REQ-025 When HOLD ends, cs SHALL fall, done SHALL pulse for one cycle, rx_data SHALL update in that same cycle, and the FSM SHALL enter GAP.
REQ-026 The cs high time SHALL be exactly (2*W+2)*DIV cycles.
REQ-027 GAP SHALL last GAP cycles (zero means skipped) with busy=1; the FSM then returns to IDLE and busy falls.
REQ-028 A start asserted outside IDLE SHALL be ignored and SHALL NOT be queued; start held high SHALL begin a new frame on the first IDLE cycle.
REQ-029 A tx_data change after acceptance SHALL have no effect on the frame in flight.
REQ-030 The cycle counter SHALL use ceil(log2(DIV+1)) bits and the bit counter ceil(log2(W+1)) bits; neither SHALL wrap mid-frame.

Reset
REQ-031 While rst=1 on a clock edge, the module SHALL set cs=0, sclk=0, sdo=0, busy=0, done=0, rx_data=0, lat=0 and lat_valid=0, and the FSM SHALL return to IDLE.
REQ-032 A reset mid-frame SHALL abort the frame with no done pulse and no rx_data update; the first start after reset release SHALL be honoured.

Configuration
REQ-033 With LAT_MEAS_EN defined, an 8-bit counter SHALL start at 0 on the cycle cs rises and increment each cycle until the first cycle cs_ret=1 is seen.
REQ-034 With LAT_MEAS_EN defined, the latency counter SHALL saturate at 255 when cs_ret is not seen before done, and lat SHALL be loaded with the counter value at done with lat_valid=1 for that cycle.
REQ-035 With LAT_MEAS_EN undefined, the lat and lat_valid ports SHALL remain present, be tied to 0, and cs_ret SHALL be ignored.

Structure
REQ-036 The shared package spi_init_pkg SHALL hold the FSM state enum, the default DIV/W/GAP constants and the LAT_SAT=255 constant.
REQ-037 The sub-module sclk_div_tick SHALL be a DIV-cycle tick generator with restart input, instantiated once.

Verification
REQ-038 With DIV=2, W=8, GAP=2, start with tx_data=0xA5 and miso looped from sdo SHALL produce sdo bits 1,0,1,0,0,1,0,1, cs high for 36 cycles, one done pulse and rx_data=0xA5.
REQ-039 With miso tied to 1, rx_data SHALL be 0xFF; with miso tied to 0, rx_data SHALL be 0x00.
REQ-040 A start pulse 10 cycles into a frame SHALL produce no second frame; start held high SHALL give a second cs rise exactly GAP+2 cycles after done.
REQ-041 A rst pulse in SHIFT SHALL drive cs, sclk and sdo to 0 on the next cycle with no done; a start 3 cycles later SHALL run a full clean frame.
REQ-042 With LAT_MEAS_EN defined and cs_ret = cs delayed 5 cycles, the bench SHALL see lat=5 at done; with cs_ret held at 0, lat=255; with the macro undefined, lat=0 and lat_valid=0 always.
